l1_icache: RTL and testbench

//  Direct-mapped L1 instruction cache; responder to the per-strand fetch requests of the fetch stage.
//  - Lookup result (data/hit/collision) is returned exactly one cycle after each request.
//  - Misses are tracked per cache line in a small miss table, which merges strands missing on the same line.
//  - Misses are refilled from L2 one line at a time, in allocation order.
//  - Waiting strands are released with a one-cycle load-complete pulse.

---
 rtl/l1_icache.sv | 196 +++++++++++++++++++
 tb/tb_l1_icache.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/l1_icache.sv
// l1_icache: direct-mapped L1 instruction cache serving per-strand fetch requests.
//   Lookup results (data/hit/collision) return one cycle after the request.
//   Misses are tracked per line in a small in-order miss table that merges
//   strands missing on the same line. Lines are refilled from L2 one at a time
//   in allocation order, and waiting strands are released by a one-cycle
//   load-complete pulse.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   icache_request/addr/req_strand lookup request (addr[1:0] ignored)
//   icache_data/hit                word of the line, hit flag (request cycle + 1)
//   icache_load_collision          miss that was not recorded; strand must retry
//   icache_load_complete_strands   strands whose line was just filled
//   l2_req_valid/addr/ready        line fill request handshake (addr[31:6])
//   l2_resp_valid/data             fill data for the issued request
module l1_icache #(
  parameter int NUM_SETS           = 64,
  parameter int LINE_BYTES         = 64,
  parameter int MISS_ENTRIES       = 2,
  parameter int STRANDS_PER_CORE   = 4,
  parameter int STRAND_INDEX_WIDTH = $clog2(STRANDS_PER_CORE)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          icache_request,
  input  logic [31:0]                   icache_addr,
  input  logic [STRAND_INDEX_WIDTH-1:0] icache_req_strand,
  output logic [31:0]                   icache_data,
  output logic                          icache_hit,
  output logic                          icache_load_collision,
  output logic [STRANDS_PER_CORE-1:0]   icache_load_complete_strands,
  output logic                          l2_req_valid,
  output logic [25:0]                   l2_req_addr,
  input  logic                          l2_req_ready,
  input  logic                          l2_resp_valid,
  input  logic [LINE_BYTES*8-1:0]       l2_resp_data
);

  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int SET_W     = $clog2(NUM_SETS);
  localparam int TAG_W     = 26 - SET_W;
  localparam int PTR_W     = (MISS_ENTRIES > 1) ? $clog2(MISS_ENTRIES) : 1;

  // Cache storage
  logic [NUM_SETS-1:0]  valid_bits;
  logic [TAG_W-1:0]     tag_mem  [NUM_SETS];
  logic [LINE_BITS-1:0] data_mem [NUM_SETS];

  // Lookup pipeline register (request cycle -> response cycle)
  logic                          req_q;
  logic [25:0]                   line_q;
  logic [STRAND_INDEX_WIDTH-1:0] strand_q;
  logic                          rd_valid_q;
  logic [TAG_W-1:0]              rd_tag_q;
  logic [31:0]                   rd_word_q;

  // Miss table, kept as an in-order ring: head is the oldest entry and the
  // only one that can be issued, so fills always free the head.
  logic [MISS_ENTRIES-1:0]     ent_valid;
  logic [MISS_ENTRIES-1:0]     ent_issued;
  logic [25:0]                 ent_line [MISS_ENTRIES];
  logic [STRANDS_PER_CORE-1:0] ent_mask [MISS_ENTRIES];
  logic [PTR_W-1:0]            head_ptr;
  logic [PTR_W-1:0]            tail_ptr;
  logic                        release_q;  // fill happened last cycle; head is released now

  logic [SET_W-1:0] set_in;
  logic [3:0]       word_in;
  logic             unused_addr_bits;

  assign set_in           = icache_addr[6 +: SET_W];
  assign word_in          = icache_addr[5:2];
  assign unused_addr_bits = ^icache_addr[1:0];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MISS_ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  // Response-cycle decode
  logic [25:0]                 head_line;
  logic [SET_W-1:0]            head_set;
  logic                        hit;
  logic                        miss;
  logic                        fill_coll;
  logic [MISS_ENTRIES-1:0]     match_vec;
  logic                        full;
  logic [STRANDS_PER_CORE-1:0] pending;
  logic [STRANDS_PER_CORE-1:0] strand_bit;
  logic                        do_merge;
  logic                        do_alloc;

  assign head_line = ent_line[head_ptr];
  assign head_set  = head_line[SET_W-1:0];
  assign hit       = req_q && rd_valid_q && (rd_tag_q == line_q[25:SET_W]);
  assign miss      = req_q && !hit;
  // The set being written now (fill cycle) or just written (release cycle) is
  // unsafe to record a miss against: the lookup may have read stale contents,
  // or the strand would wait across the release of its own line.
  assign fill_coll = (l2_resp_valid || release_q) && (line_q[SET_W-1:0] == head_set);

  // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    match_vec  = '0;
    full       = 1'b1;
    pending    = '0;
    strand_bit = '0;
    strand_bit[strand_q] = 1'b1;
    for (int i = 0; i < MISS_ENTRIES; i++) begin
      match_vec[i] = ent_valid[i] && (ent_line[i] == line_q);
      full         = full && ent_valid[i];
      if (ent_valid[i]) pending = pending | ent_mask[i];
    end
  end

  assign do_merge = miss && !fill_coll && (|match_vec);
  assign do_alloc = miss && !fill_coll && !(|match_vec) && !full;

  assign icache_hit                   = hit;
  assign icache_data                  = rd_word_q;
  assign icache_load_collision        = miss && !do_merge && !do_alloc;
  assign icache_load_complete_strands = release_q ? ent_mask[head_ptr] : '0;
  assign l2_req_valid                 = ent_valid[head_ptr] && !ent_issued[head_ptr];
  assign l2_req_addr                  = head_line;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q      <= 1'b0;
      line_q     <= '0;
      strand_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
      rd_word_q  <= '0;
      valid_bits <= '0;
    end else begin
      req_q <= icache_request;
      if (icache_request) begin
        line_q     <= icache_addr[31:6];
        strand_q   <= icache_req_strand;
        rd_valid_q <= valid_bits[set_in];
        rd_tag_q   <= tag_mem[set_in];
        rd_word_q  <= data_mem[set_in][{word_in, 5'b0} +: 32];
      end
      if (l2_resp_valid) valid_bits[head_set] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; the reset valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (l2_resp_valid) begin
      tag_mem[head_set]  <= head_line[25:SET_W];
      data_mem[head_set] <= l2_resp_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid  <= '0;
      ent_issued <= '0;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      release_q  <= 1'b0;
      for (int i = 0; i < MISS_ENTRIES; i++) begin
        ent_line[i] <= '0;
        ent_mask[i] <= '0;
      end
    end else begin
      release_q <= l2_resp_valid;
      if (l2_req_valid && l2_req_ready) ent_issued[head_ptr] <= 1'b1;
      if (do_merge) begin
        for (int i = 0; i < MISS_ENTRIES; i++)
          if (match_vec[i]) ent_mask[i] <= ent_mask[i] | strand_bit;
      end
      // Allocation never targets the head while it is being released: the
      // released entry still counts as occupied in its release cycle.
      if (do_alloc) begin
        ent_valid[tail_ptr]  <= 1'b1;
        ent_issued[tail_ptr] <= 1'b0;
        ent_line[tail_ptr]   <= line_q;
        ent_mask[tail_ptr]   <= strand_bit;
        tail_ptr             <= ptr_next(tail_ptr);
      end
      if (release_q) begin
        ent_valid[head_ptr]  <= 1'b0;
        ent_issued[head_ptr] <= 1'b0;
        head_ptr             <= ptr_next(head_ptr);
      end
    end
  end

  a_resp_has_issued: assert property (@(posedge clk) disable iff (reset)
    l2_resp_valid |-> (ent_valid[head_ptr] && ent_issued[head_ptr]));

  a_strand_not_pending: assert property (@(posedge clk) disable iff (reset)
    (do_merge || do_alloc) |-> ((pending & strand_bit) == '0));

endmodule

// File: tb/tb_l1_icache.sv
// tb_l1_icache: directed self-checking bench for l1_icache.
// Inputs change 2 time units after each rising edge; outputs are checked
// 4 time units after the edge, well clear of the next one.
module tb_l1_icache;

  logic         clk = 1'b0;
  logic         reset;
  logic         icache_request;
  logic [31:0]  icache_addr;
  logic [1:0]   icache_req_strand;
  logic [31:0]  icache_data;
  logic         icache_hit;
  logic         icache_load_collision;
  logic [3:0]   icache_load_complete_strands;
  logic         l2_req_valid;
  logic [25:0]  l2_req_addr;
  logic         l2_req_ready;
  logic         l2_resp_valid;
  logic [511:0] l2_resp_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l1_icache dut (
    .clk                          (clk),
    .reset                        (reset),
    .icache_request               (icache_request),
    .icache_addr                  (icache_addr),
    .icache_req_strand            (icache_req_strand),
    .icache_data                  (icache_data),
    .icache_hit                   (icache_hit),
    .icache_load_collision        (icache_load_collision),
    .icache_load_complete_strands (icache_load_complete_strands),
    .l2_req_valid                 (l2_req_valid),
    .l2_req_addr                  (l2_req_addr),
    .l2_req_ready                 (l2_req_ready),
    .l2_resp_valid                (l2_resp_valid),
    .l2_resp_data                 (l2_resp_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic exp_hit, input logic exp_coll);
    check({tag, "_hit"}, 32'(icache_hit), 32'(exp_hit));
    check({tag, "_coll"}, 32'(icache_load_collision), 32'(exp_coll));
  endtask

  task automatic l2req(input string tag, input logic exp_valid, input logic [25:0] exp_addr);
    check({tag, "_l2v"}, 32'(l2_req_valid), 32'(exp_valid));
    if (exp_valid) check({tag, "_l2a"}, 32'(l2_req_addr), 32'(exp_addr));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
    icache_request = 1'b0;
    l2_resp_valid  = 1'b0;
    l2_req_ready   = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic req(input int strand, input logic [31:0] addr);
    icache_request    = 1'b1;
    icache_addr       = addr;
    icache_req_strand = 2'(strand);
  endtask

  // Fill line whose word k holds base + k.
  task automatic resp(input logic [31:0] base);
    l2_resp_valid = 1'b1;
    for (int k = 0; k < 16; k++) l2_resp_data[k*32 +: 32] = base + 32'(k);
  endtask

  initial begin
    reset             = 1'b1;
    icache_request    = 1'b0;
    icache_addr       = '0;
    icache_req_strand = '0;
    l2_req_ready      = 1'b0;
    l2_resp_valid     = 1'b0;
    l2_resp_data      = '0;
    #1;
    look("reset", 1'b0, 1'b0);
    check("reset_data", icache_data, 32'h0);
    check("reset_complete", 32'(icache_load_complete_strands), 32'h0);
    l2req("reset", 1'b0, 26'h0);
    @(posedge clk);
    #2 reset = 1'b0;

    // 1. Cold miss, fill, re-request hits
    next_cycle(); req(0, 32'h1000); settle();
    next_cycle(); settle(); look("t1_miss", 1'b0, 1'b0); l2req("t1_noreq_yet", 1'b0, 26'h0);
    next_cycle(); l2_req_ready = 1'b1; settle(); l2req("t1_issue", 1'b1, 26'h40);
    next_cycle(); resp(32'h1000_0000); settle(); l2req("t1_issued", 1'b0, 26'h0);
    check("t1_no_early_complete", 32'(icache_load_complete_strands), 32'h0);
    next_cycle(); req(0, 32'h1000); settle();
    check("t1_complete", 32'(icache_load_complete_strands), 32'b0001);
    next_cycle(); settle(); look("t1_rehit", 1'b1, 1'b0);
    check("t1_data", icache_data, 32'h1000_0000);
    check("t1_pulse_one_cycle", 32'(icache_load_complete_strands), 32'h0);

    // 2. Word select
    next_cycle(); req(1, 32'h2000); settle();
    next_cycle(); settle(); look("t2_miss", 1'b0, 1'b0);
    next_cycle(); l2_req_ready = 1'b1; settle(); l2req("t2_issue", 1'b1, 26'h80);
    next_cycle(); resp(32'h0); settle();
    next_cycle(); req(1, 32'h2000); settle();
    check("t2_complete", 32'(icache_load_complete_strands), 32'b0010);
    next_cycle(); req(1, 32'h2004); settle(); look("t2_w0", 1'b1, 1'b0);
    check("t2_w0_data", icache_data, 32'd0);
    next_cycle(); req(1, 32'h203C); settle(); look("t2_w1", 1'b1, 1'b0);
    check("t2_w1_data", icache_data, 32'd1);
    next_cycle(); settle(); look("t2_w15", 1'b1, 1'b0);
    check("t2_w15_data", icache_data, 32'd15);

    // 3. Merge two strands onto one line
    next_cycle(); req(1, 32'h3000); settle();
    next_cycle(); req(3, 32'h3008); settle(); look("t3_alloc", 1'b0, 1'b0);
    next_cycle(); settle(); look("t3_merge", 1'b0, 1'b0); l2req("t3_issue", 1'b1, 26'hC0);
    next_cycle(); l2_req_ready = 1'b1; settle(); l2req("t3_held", 1'b1, 26'hC0);
    next_cycle(); resp(32'h3000_0000); settle(); l2req("t3_single_req", 1'b0, 26'h0);
    next_cycle(); settle();
    check("t3_complete", 32'(icache_load_complete_strands), 32'b1010);
    next_cycle(); req(1, 32'h3008); settle();
    check("t3_pulse_end", 32'(icache_load_complete_strands), 32'h0);
    next_cycle(); settle(); look("t3_hit", 1'b1, 1'b0);
    check("t3_data", icache_data, 32'h3000_0002);

    // 4. Full table collision, retry after a fill
    next_cycle(); req(0, 32'h4000); settle();
    next_cycle(); req(1, 32'h5000); settle(); look("t4_a0", 1'b0, 1'b0);
    next_cycle(); req(2, 32'h6000); settle(); look("t4_a1", 1'b0, 1'b0);
    l2req("t4_issue0", 1'b1, 26'h100);
    next_cycle(); l2_req_ready = 1'b1; settle(); look("t4_full", 1'b0, 1'b1);
    next_cycle(); resp(32'h4000_0000); settle(); l2req("t4_one_out", 1'b0, 26'h0);
    next_cycle(); req(2, 32'h6000); settle();
    check("t4_complete0", 32'(icache_load_complete_strands), 32'b0001);
    l2req("t4_not_yet", 1'b0, 26'h0);
    next_cycle(); l2_req_ready = 1'b1; settle(); look("t4_retry", 1'b0, 1'b0);
    l2req("t4_issue1", 1'b1, 26'h140);
    next_cycle(); resp(32'h5000_0000); settle(); l2req("t4_wait2", 1'b0, 26'h0);
    next_cycle(); settle();
    check("t4_complete1", 32'(icache_load_complete_strands), 32'b0010);
    next_cycle(); l2_req_ready = 1'b1; settle(); l2req("t4_issue2", 1'b1, 26'h180);
    next_cycle(); resp(32'h6000_0000); settle();
    next_cycle(); settle();
    check("t4_complete2", 32'(icache_load_complete_strands), 32'b0100);

    // 5. Fill-set collisions (fill in response cycle and in request cycle)
    next_cycle(); req(0, 32'h7000); settle();
    next_cycle(); settle(); look("t5_alloc", 1'b0, 1'b0);
    next_cycle(); l2_req_ready = 1'b1; req(2, 32'h8000); settle();
    l2req("t5_issue", 1'b1, 26'h1C0);
    next_cycle(); resp(32'h7000_0000); req(1, 32'h7004); settle();
    look("t5_coll_fill_now", 1'b0, 1'b1);
    next_cycle(); req(1, 32'h7004); settle(); look("t5_coll_fill_prev", 1'b0, 1'b1);
    check("t5_complete", 32'(icache_load_complete_strands), 32'b0001);
    next_cycle(); settle(); look("t5_hit", 1'b1, 1'b0);
    check("t5_data", icache_data, 32'h7000_0001);
    l2req("t5_no_entry", 1'b0, 26'h0);
    next_cycle(); settle(); l2req("t5_no_entry2", 1'b0, 26'h0);

    // 6. Reset with a fill outstanding
    next_cycle(); req(0, 32'h9000); settle();
    next_cycle(); settle(); look("t6_alloc", 1'b0, 1'b0);
    next_cycle(); l2_req_ready = 1'b1; settle(); l2req("t6_issue", 1'b1, 26'h240);
    next_cycle(); reset = 1'b1; settle();
    look("t6_reset", 1'b0, 1'b0);
    check("t6_reset_data", icache_data, 32'h0);
    check("t6_reset_complete", 32'(icache_load_complete_strands), 32'h0);
    l2req("t6_reset", 1'b0, 26'h0);
    next_cycle(); reset = 1'b0; settle();
    check("t6_no_complete", 32'(icache_load_complete_strands), 32'h0);
    next_cycle(); req(1, 32'h7000); settle();
    next_cycle(); settle(); look("t6_line_lost", 1'b0, 1'b0);
    check("t6_no_complete2", 32'(icache_load_complete_strands), 32'h0);
    next_cycle(); l2_req_ready = 1'b1; settle(); l2req("t6_fresh_issue", 1'b1, 26'h1C0);
    next_cycle(); resp(32'h7000_0000); settle();
    next_cycle(); settle();
    check("t6_complete", 32'(icache_load_complete_strands), 32'b0010);

    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
